uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver, the counterpart of the stopwatch's existing transmitter. Recovers 8N1-style serial frames from the asynchronous `rx` line using the shared 16× oversampling `s_tick` from the baud generator. Presents each received byte on `dout` with a one-cycle `rx_done_tick`, and reports bad stop bits on `frame_err`. Sits between the board RX pin and the command decoder (start/stop/clear/lap keys).

## Interface
- `DBIT`, 8: data bits per frame, 5..8, LSB first.
- `SB_TICK`, 16: stop-bit length in `s_tick` periods (16 = 1, 24 = 1.5, 32 = 2 stop bits).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `s_tick`  in  1  one-`clk` pulse at 16× baud rate.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `dout`  out  8  last received data, right-justified; unused upper bits are 0.
- `rx_done_tick`  out  1  one-cycle pulse when a good frame is received.
- `frame_err`  out  1  one-cycle pulse when the stop sample reads 0.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1). The resulting signal is `rx_s`. `rx_s_d` is a one-cycle delayed copy used for edge detection.
- The FSM has four states: `IDLE`, `START`, `DATA`, `STOP`. Counters: `s_reg` is 5 bits and counts ticks; `n_reg` is 3 bits and counts bits. `b_reg` is an 8-bit shift register.
- `IDLE`: on `rx_s_d`=1 and `rx_s`=0 (a falling edge), clear `s_reg` and go to `START`. A line held low does not restart reception.
- `START`: on each `s_tick`, increment `s_reg`. At `s_reg`==7 (mid start bit), sample the line:
  - sample 0: clear `s_reg` and `n_reg`, go to `DATA`.
  - sample 1: treat as a glitch and return to `IDLE` with no output.
- `DATA`: on each `s_tick`, increment `s_reg`. At `s_reg`==15:
  - shift the sample into the MSB: `b_reg` = {sample, `b_reg`[7:1]}, then clear `s_reg`.
  - if `n_reg`==DBIT-1, go to `STOP`; otherwise increment `n_reg`.
- `STOP`: on each `s_tick`, increment `s_reg`. At `s_reg`==SB_TICK-1:
  - load `dout` with `b_reg` >> (8-DBIT).
  - sample 1: pulse `rx_done_tick`. Sample 0: pulse `frame_err` instead.
  - return to `IDLE` in both cases.
- `dout` holds its value until the next completed frame. `dout` is updated on a frame error too.
- `s_tick` absent: all counters hold. `rx` edges are still detected in `IDLE`.
- Reset mid-frame returns the block to `IDLE` immediately. `dout`=0 and `b_reg`=0. No pulse is emitted.
- An undefined state code goes to `IDLE`.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, state `IDLE`, counters 0.
- All outputs are registered. `rx_done_tick` and `frame_err` assert the `clk` after the `s_tick` that reaches `s_reg`==SB_TICK-1, for exactly one cycle. They never assert together.
- The `dout` update and the pulse occur in the same cycle.
- Synchronizer plus edge detect adds 3 `clk` of latency from the `rx` fall to `START` entry.
- Frame span from `START` entry to the pulse: 8 + 16·DBIT + SB_TICK ticks (default 152 ticks).
- A back-to-back frame is accepted when the next falling edge arrives at least 1 `clk` after returning to `IDLE`.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit decision is a 2-of-3 majority vote of `rx_s`, sampled at these `s_reg` values on `s_tick`:
  - `START`: 5, 6, 7.
  - `DATA`: 13, 14, 15.
  - `STOP`: SB_TICK-3, SB_TICK-2, SB_TICK-1.
  - The decision points themselves are unchanged.
- `UART_RX_MAJORITY_EN` undefined: a single sample at the decision point. The vote registers are not instantiated.

## Structure
- Shared package `uart_pkg`, used by both directions of the UART: state encodings (`IDLE`, `START`, `DATA`, `STOP`), `OVERSAMPLE`=16, and the mid-start tick constant 7.
- One sub-module: `uart_rx_sync`, a 2-flop synchronizer with a reset value parameter. It is reusable for the button inputs.

## Test plan
- Good frame: send 0xA5 (8N1) at 16 ticks/bit → `dout`=0xA5, one `rx_done_tick`, `frame_err` stays 0.
- Glitch rejection: drive `rx` low for 4 ticks then high → no pulse, FSM back in `IDLE`, `dout` unchanged. A following 0x3C frame is received correctly.
- Frame error: send 0x81 with the stop bit held 0 → `frame_err` pulses once, `dout`=0x81, no `rx_done_tick`. The line stays low afterward and no new frame starts until it returns high.
- Back-to-back: 0x00 immediately followed by 0xFF → two `rx_done_tick` pulses, `dout` reads 0x00 then 0xFF.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x55 → outputs 0 immediately, no pulse. After release, 0x12 is received correctly.
- Majority (`UART_RX_MAJORITY_EN` defined): send 0xF0 with bit 0 forced high for 1 `clk`-wide tick at `s_reg`=14 → `dout`=0xF0. With the macro undefined and the glitch at `s_reg`=15 → `dout`=0xF1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, oversampling ratio and the
// mid-start tick used by both directions of the link.
package uart_pkg;
  localparam int OVERSAMPLE     = 16;
  localparam int MID_START_TICK = 7;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs (RX pin, buttons).
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, DBIT data bits LSB first, SB_TICK stop ticks.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each decision point.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);
  import uart_pkg::*;

  localparam logic [4:0] MID_S     = 5'(MID_START_TICK);
  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  logic       w_rx_s;
  logic       w_sample;
  logic       r_rx_s_d;
  logic [1:0] r_state;
  logic [4:0] r_s;
  logic [2:0] r_n;
  logic [7:0] r_b;
  logic [7:0] r_dout;
  logic       r_done;
  logic       r_ferr;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two earlier samples are banked; the third is the live value at the decision tick.
  logic [1:0] r_vote;
  logic       w_vote_en;

  always_comb begin
    w_vote_en = 1'b0;
    case (r_state)
      START:   w_vote_en = (r_s == MID_S - 5'd2) || (r_s == MID_S - 5'd1);
      DATA:    w_vote_en = (r_s == BIT_LAST - 5'd2) || (r_s == BIT_LAST - 5'd1);
      STOP:    w_vote_en = (r_s == STOP_LAST - 5'd2) || (r_s == STOP_LAST - 5'd1);
      default: w_vote_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_vote <= 2'b11;
    else if (s_tick && w_vote_en) r_vote <= {r_vote[0], w_rx_s};
  end

  assign w_sample = maj3(r_vote[1], r_vote[0], w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s_d <= 1'b1;
      r_state  <= IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_b      <= '0;
      r_dout   <= '0;
      r_done   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_rx_s_d <= w_rx_s;
      r_done   <= 1'b0;
      r_ferr   <= 1'b0;
      case (r_state)
        IDLE: begin
          // Edge, not level: a line stuck low after a framing error stays idle.
          if (r_rx_s_d && !w_rx_s) begin
            r_s     <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == MID_S) begin
              if (!w_sample) begin
                r_s     <= '0;
                r_n     <= '0;
                r_state <= DATA;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == BIT_LAST) begin
              r_b <= {w_sample, r_b[7:1]};
              r_s <= '0;
              if (r_n == N_LAST) r_state <= STOP;
              else               r_n     <= r_n + 3'd1;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s == STOP_LAST) begin
              r_dout  <= r_b >> (8 - DBIT);
              r_done  <= w_sample;
              r_ferr  <= ~w_sample;
              r_state <= IDLE;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a negedge
// monitor pops and compares on every rx_done_tick / frame_err pulse.
module tb_uart_rx;
  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;
  exp_t q[$];

  uart_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tick      (s_tick),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rx_done_tick || frame_err)) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: done=%b err=%b dout=%h expected no pulse",
                 rx_done_tick, frame_err, dout);
      end else begin
        e = q.pop_front();
        check("pulse_kind", {30'd0, rx_done_tick, frame_err}, {30'd0, ~e.err, e.err});
        check("dout", {24'd0, dout}, {24'd0, e.data});
      end
    end
  end

  task automatic wait_tick;
    do @(posedge clk); while (s_tick !== 1'b1);
  endtask

  // Tick t of the frame is the t-th tick edge after the start-bit drive edge.
  // glitch_tick: rx_s reads high for exactly the tick edge glitch_tick.
  // rst_tick: assert reset at that tick and abandon the frame.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic [7:0] exp_data, input int glitch_tick,
                            input int rst_tick);
    logic cur;
    if (rst_tick == 0) q.push_back({~stop_bit, exp_data});
    wait_tick;
    #1 rx = 1'b0;
    cur = 1'b0;
    for (int t = 1; t <= 160; t++) begin
      if (t == glitch_tick) begin
        @(posedge clk); #1 rx = 1'b1;
        @(posedge clk); #1 rx = cur;
      end
      wait_tick;
      if (t == rst_tick) begin
        #1 rst_n = 1'b0;
        return;
      end
      if (t % 16 == 0 && t / 16 <= 9) begin
        cur = (t / 16 == 9) ? stop_bit : data[t / 16 - 1];
        #1 rx = cur;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", {24'd0, dout}, 32'h0);
    check("reset_done", {31'd0, rx_done_tick}, 32'h0);
    check("reset_ferr", {31'd0, frame_err}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) wait_tick;

    send_frame(8'hA5, 1'b1, 8'hA5, 0, 0);

    // Short low pulse: rejected at the mid-start sample
    wait_tick; #1 rx = 1'b0;
    repeat (4) wait_tick;
    #1 rx = 1'b1;
    repeat (20) wait_tick;
    check("glitch_dout_hold", {24'd0, dout}, 32'hA5);

    send_frame(8'h3C, 1'b1, 8'h3C, 0, 0);

    // Framing error, line then held low: no new frame may start
    send_frame(8'h81, 1'b0, 8'h81, 0, 0);
    repeat (40) wait_tick;
    #1 rx = 1'b1;
    repeat (20) wait_tick;
    check("ferr_dout_hold", {24'd0, dout}, 32'h81);

    send_frame(8'h00, 1'b1, 8'h00, 0, 0);
    send_frame(8'hFF, 1'b1, 8'hFF, 0, 0);

    // Reset in the middle of data bit 3
    send_frame(8'h55, 1'b1, 8'h55, 0, 68);
    #1;
    check("midrst_dout", {24'd0, dout}, 32'h0);
    check("midrst_done", {31'd0, rx_done_tick}, 32'h0);
    check("midrst_ferr", {31'd0, frame_err}, 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) wait_tick;
    send_frame(8'h12, 1'b1, 8'h12, 0, 0);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hF0, 1'b1, 8'hF0, 23, 0);
`else
    send_frame(8'hF0, 1'b1, 8'hF1, 24, 0);
`endif

    repeat (10) wait_tick;
    check("queue_drained", q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
